// File: rtl/fpu_itof_arbiter.sv
// Round-robin share of one external combinational int-to-float unit among NREQ
// requesters, with a 2-stage registered pipeline (operand stage, result stage).
module fpu_itof_arbiter #(
   parameter int NREQ = 2,
   parameter int TAGW = 5,
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [32*NREQ-1:0]   req_src,
   input  logic [TAGW*NREQ-1:0] req_tag,
   output logic [31:0]          conv_s,
   input  logic [31:0]          conv_d,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [31:0]          resp_data,
   output logic [TAGW-1:0]      resp_tag,
   output logic [IDW-1:0]       resp_id,
   output logic [1:0]           inflight,
   output logic [31:0]          conv_count
);

   logic            s1_v, s2_v;
   logic [31:0]     s1_op, s2_d;
   logic [TAGW-1:0] s1_tag, s2_tag;
   logic [IDW-1:0]  s1_id, s2_id;
   logic [IDW-1:0]  rr;

   logic            s2_free, s1_adv, s1_free;
   logic            gnt_any, acc, pop;
   logic [IDW-1:0]  gnt_idx;

   assign s2_free = ~s2_v | resp_ready;
   assign s1_adv  = s1_v & s2_free;
   assign s1_free = ~s1_v | s1_adv;
   assign pop     = s2_v & resp_ready;

   // First set valid bit scanning upward from the round-robin pointer.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!gnt_any && req_valid[(int'(rr) + k) % NREQ]) begin
            gnt_any = 1'b1;
            gnt_idx = IDW'((int'(rr) + k) % NREQ);
         end
      end
   end

   assign acc       = gnt_any & s1_free & rstn;
   assign req_ready = acc ? (NREQ'(1) << gnt_idx) : '0;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_v   <= 1'b0;
         s1_op  <= '0;
         s1_tag <= '0;
         s1_id  <= '0;
         rr     <= '0;
      end else begin
         if (acc) begin
            s1_v   <= 1'b1;
            s1_op  <= req_src[int'(gnt_idx)*32 +: 32];
            s1_tag <= req_tag[int'(gnt_idx)*TAGW +: TAGW];
            s1_id  <= gnt_idx;
            rr     <= IDW'((int'(gnt_idx) + 1) % NREQ);
         end else if (s1_adv) begin
            s1_v <= 1'b0;
         end
      end
   end

   // S2 reloads on advance even when popping in the same cycle, so no bubble.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s2_v       <= 1'b0;
         s2_d       <= '0;
         s2_tag     <= '0;
         s2_id      <= '0;
         conv_count <= '0;
      end else begin
         if (s1_adv) begin
            s2_v   <= 1'b1;
            s2_d   <= conv_d;
            s2_tag <= s1_tag;
            s2_id  <= s1_id;
         end else if (pop) begin
            s2_v <= 1'b0;
         end
         if (pop) conv_count <= conv_count + 32'd1;
      end
   end

   assign conv_s     = s1_v ? s1_op : 32'd0;
   assign resp_valid = s2_v;
   assign resp_data  = s2_d;
   assign resp_tag   = s2_tag;
   assign resp_id    = s2_id;
   assign inflight   = {1'b0, s1_v} + {1'b0, s2_v};

endmodule

// File: tb/tb_fpu_itof_arbiter.sv
// Directed bench for fpu_itof_arbiter with an attached RNE int-to-float model
// driving conv_d; expected responses are hand-computed constants.
module tb_fpu_itof_arbiter;
   localparam int NREQ = 2;
   localparam int TAGW = 5;

   logic            clk = 1'b0;
   logic            rstn;
   logic [1:0]      req_valid;
   logic [1:0]      req_ready;
   logic [63:0]     req_src;
   logic [9:0]      req_tag;
   logic [31:0]     conv_s, conv_d;
   logic            resp_valid, resp_ready;
   logic [31:0]     resp_data;
   logic [4:0]      resp_tag;
   logic            resp_id;
   logic [1:0]      inflight;
   logic [31:0]     conv_count;

   int n_chk = 0;
   int n_err = 0;

   fpu_itof_arbiter #(.NREQ(NREQ), .TAGW(TAGW)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_src(req_src), .req_tag(req_tag),
      .conv_s(conv_s), .conv_d(conv_d),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_tag(resp_tag), .resp_id(resp_id),
      .inflight(inflight), .conv_count(conv_count)
   );

   always #5 clk = ~clk;

   // Attached converter: int32 to IEEE single, round-to-nearest-even.
   function automatic logic [31:0] itof(input logic [31:0] x);
      logic        sgn;
      logic [31:0] mag, rem, half;
      logic [32:0] man;
      int          p, sh, e;
      if (x == 32'd0) return 32'd0;
      sgn = x[31];
      mag = sgn ? (~x + 32'd1) : x;
      p = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) p = i;
      e = 127 + p;
      if (p <= 23) begin
         man = {1'b0, mag} << (23 - p);
      end else begin
         sh   = p - 23;
         man  = {1'b0, mag >> sh};
         rem  = mag & ((32'd1 << sh) - 32'd1);
         half = 32'd1 << (sh - 1);
         if (rem > half || (rem == half && man[0])) man = man + 33'd1;
         if (man[24]) begin
            man = man >> 1;
            e   = e + 1;
         end
      end
      return {sgn, e[7:0], man[22:0]};
   endfunction

   assign conv_d = itof(conv_s);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance to the next falling edge, where stimulus is applied.
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic drive(input logic [1:0] v, input logic [31:0] s0, input logic [31:0] s1,
                        input logic [4:0] t0, input logic [4:0] t1);
      req_valid = v;
      req_src   = {s1, s0};
      req_tag   = {t1, t0};
   endtask

   logic [31:0] rr_data [2];

   initial begin
      rstn = 1'b0;
      resp_ready = 1'b1;
      drive(2'b01, 32'd3, 32'd0, 5'd7, 5'd0);
      cyc(); #1;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_data", resp_data, 32'd0);
      check("rst_inflight", 32'(inflight), 32'd0);
      check("rst_conv_count", conv_count, 32'd0);
      check("rst_resp_tag_id", {26'd0, resp_tag, resp_id}, 32'd0);

      // Single request: first grant possible in first cycle after release
      rstn = 1'b1; #1;
      check("t1_ready", 32'(req_ready), 32'd1);
      cyc(); drive(2'b00, 32'd0, 32'd0, 5'd0, 5'd0); #1;
      check("t1_inflight", 32'(inflight), 32'd1);
      check("t1_no_early_resp", 32'(resp_valid), 32'd0);
      cyc(); #1;
      check("t1_resp_valid", 32'(resp_valid), 32'd1);
      check("t1_resp_data", resp_data, 32'h40400000);
      check("t1_resp_tag", 32'(resp_tag), 32'd7);
      check("t1_resp_id", 32'(resp_id), 32'd0);
      cyc(); #1;
      check("t1_conv_count", conv_count, 32'd1);
      check("t1_resp_drop", 32'(resp_valid), 32'd0);

      // Back-to-back from requester 1 (rr now 1)
      cyc(); drive(2'b10, 32'd0, 32'd1, 5'd0, 5'd1); #1;
      check("b2b_ready0", 32'(req_ready), 32'd2);
      cyc(); drive(2'b10, 32'd0, 32'hFFFFFFFF, 5'd0, 5'd2); #1;
      check("b2b_ready1", 32'(req_ready), 32'd2);
      check("b2b_infl1", 32'(inflight), 32'd1);
      cyc(); drive(2'b10, 32'd0, 32'd100, 5'd0, 5'd3); #1;
      check("b2b_ready2", 32'(req_ready), 32'd2);
      check("b2b_infl2", 32'(inflight), 32'd2);
      check("b2b_d0", resp_data, 32'h3F800000);
      check("b2b_tag0", 32'(resp_tag), 32'd1);
      check("b2b_id0", 32'(resp_id), 32'd1);
      cyc(); drive(2'b00, 32'd0, 32'd0, 5'd0, 5'd0); #1;
      check("b2b_infl3", 32'(inflight), 32'd2);
      check("b2b_d1", resp_data, 32'hBF800000);
      check("b2b_v1", 32'(resp_valid), 32'd1);
      cyc(); #1;
      check("b2b_d2", resp_data, 32'h42C80000);
      check("b2b_tag2", 32'(resp_tag), 32'd3);
      cyc(); #1;
      check("b2b_idle", 32'(resp_valid), 32'd0);
      check("b2b_count", conv_count, 32'd4);

      // Round-robin: both valid for 6 cycles, rr back at 0
      rr_data[0] = 32'h41200000;  // 10.0
      rr_data[1] = 32'h41A00000;  // 20.0
      for (int i = 0; i < 8; i++) begin
         cyc();
         if (i < 6) drive(2'b11, 32'd10, 32'd20, 5'd4, 5'd9);
         else       drive(2'b00, 32'd0, 32'd0, 5'd0, 5'd0);
         #1;
         if (i < 6) check($sformatf("rr_grant%0d", i), 32'(req_ready), (i % 2) ? 32'd2 : 32'd1);
         if (i >= 2) begin
            check($sformatf("rr_valid%0d", i), 32'(resp_valid), 32'd1);
            check($sformatf("rr_id%0d", i), 32'(resp_id), 32'((i - 2) % 2));
            check($sformatf("rr_data%0d", i), resp_data, rr_data[(i - 2) % 2]);
         end
      end
      cyc(); #1;
      check("rr_count", conv_count, 32'd10);
      check("rr_idle", 32'(resp_valid), 32'd0);

      // Backpressure with requester 0 issuing 5, 6, 7
      drive(2'b01, 32'd5, 32'd0, 5'd1, 5'd0); #1;
      check("bp_ready0", 32'(req_ready), 32'd1);
      cyc(); resp_ready = 1'b0; drive(2'b01, 32'd6, 32'd0, 5'd2, 5'd0); #1;
      check("bp_ready1", 32'(req_ready), 32'd1);
      for (int i = 0; i < 2; i++) begin
         cyc(); drive(2'b01, 32'd7, 32'd0, 5'd3, 5'd0); #1;
         check($sformatf("bp_stall_ready%0d", i), 32'(req_ready), 32'd0);
         check($sformatf("bp_stall_infl%0d", i), 32'(inflight), 32'd2);
         check($sformatf("bp_stall_data%0d", i), resp_data, 32'h40A00000);
         check($sformatf("bp_stall_tag%0d", i), 32'(resp_tag), 32'd1);
      end
      cyc(); resp_ready = 1'b1; #1;
      check("bp_release_ready", 32'(req_ready), 32'd1);
      check("bp_release_data", resp_data, 32'h40A00000);
      cyc(); drive(2'b00, 32'd0, 32'd0, 5'd0, 5'd0); #1;
      check("bp_d6", resp_data, 32'h40C00000);
      check("bp_t6", 32'(resp_tag), 32'd2);
      cyc(); #1;
      check("bp_d7", resp_data, 32'h40E00000);
      check("bp_t7", 32'(resp_tag), 32'd3);
      cyc(); #1;
      check("bp_idle", 32'(resp_valid), 32'd0);
      check("bp_count", conv_count, 32'd13);

      // Rounding passthrough: 2^24+1 ties to even
      drive(2'b01, 32'd16777217, 32'd0, 5'd11, 5'd0); #1;
      check("rnd_ready", 32'(req_ready), 32'd1);
      cyc(); drive(2'b00, 32'd0, 32'd0, 5'd0, 5'd0); #1;
      check("rnd_conv_s", conv_s, 32'd16777217);
      cyc(); #1;
      check("rnd_data", resp_data, 32'h4B800000);
      check("rnd_tag", 32'(resp_tag), 32'd11);
      cyc(); #1;

      // Reset mid-flight with two entries held by backpressure
      resp_ready = 1'b0;
      drive(2'b01, 32'd2, 32'd0, 5'd5, 5'd0);
      cyc(); drive(2'b01, 32'd3, 32'd0, 5'd6, 5'd0);
      cyc(); #1;
      check("mr_infl_pre", 32'(inflight), 32'd2);
      rstn = 1'b0; #1;
      check("mr_infl", 32'(inflight), 32'd0);
      check("mr_resp_valid", 32'(resp_valid), 32'd0);
      check("mr_resp_data", resp_data, 32'd0);
      check("mr_count", conv_count, 32'd0);
      check("mr_ready", 32'(req_ready), 32'd0);
      cyc(); rstn = 1'b1; resp_ready = 1'b1; drive(2'b00, 32'd0, 32'd0, 5'd0, 5'd0);
      for (int i = 0; i < 3; i++) begin
         cyc(); #1;
         check($sformatf("mr_no_stale%0d", i), 32'(resp_valid), 32'd0);
      end
      check("mr_count_post", conv_count, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
